lsu_dmem_responder: RTL and testbench
=====================================

# lsu_dmem_responder

Data-memory responder serving the load/store requests issued by the two LSU lanes of the VLIW core. It accepts per-lane read and write requests, stores data in a word-addressed RAM, and returns load data one cycle after a read. Returned data is timed so that the LSU writeback stage consumes it when the request reaches the EX/WB boundary. It also clears memory after reset, resolves same-word conflicts between lanes deterministically, and flags misaligned accesses.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- CLEAR_ON_RST, 1: 1 zeroes every word after reset, 0 skips clearing.

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds the read-data registers.
- rd_addr0, rd_addr1  in  32  lane 0/1 load byte address.
- rd_en0, rd_en1  in  1  lane 0/1 read enable.
- rd_data0, rd_data1  out  32  lane 0/1 load data, registered.
- wr_addr0, wr_addr1  in  32  lane 0/1 store byte address.
- wr_data0, wr_data1  in  32  lane 0/1 store data.
- wr_en0, wr_en1  in  1  lane 0/1 write enable.
- busy  out  1  high while the clear sequence runs; all requests are ignored.
- misalign_err  out  1  sticky flag: an enabled access had addr[1:0] != 0.
- conflict  out  1  one-cycle pulse: both lanes wrote the same word in the previous cycle.

## Operation
Address handling:
- Word index = addr[$clog2(DEPTH_WORDS)+1:2].
- Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- A misaligned address is still accessed at its aligned word.

State machine, states CLEAR and READY:
- While rst=1, the next state is CLEAR if CLEAR_ON_RST=1, otherwise READY.
- CLEAR: the counter clr_idx starts at 0. Each cycle writes 0 to mem[clr_idx] and increments clr_idx. After the cycle that writes index DEPTH_WORDS-1, the state moves to READY.
- In CLEAR, busy=1, all rd_en/wr_en inputs are ignored, rd_data0/1 stay 0, and misalign_err does not update.
- Asserting rst mid-clear restarts the sequence at clr_idx=0.
- READY is absorbing until the next rst.

Writes (READY only):
- wr_enN=1 commits wr_dataN to the indexed word at the clock edge.
- If both lanes write the same word, lane 1 wins and conflict=1 on the following cycle.
- Writes commit regardless of stall. A store held in EX by a stall is reissued; this is idempotent.

Reads (READY only):
- rd_enN=1 and stall=0: rd_dataN is loaded with the word's value at the next edge.
- Same-cycle bypass: if a lane writes the read word in that same cycle, rd_dataN gets the new write data. If both lanes write that word, lane 1's data is returned.
- rd_enN=0 or stall=1: rd_dataN holds its value.

misalign_err:
- Set when any enabled request in READY has addr[1:0] != 0.
- Cleared only by rst.

Reset values: rd_data0=rd_data1=0, misalign_err=0, conflict=0, busy=CLEAR_ON_RST.

## Timing
- Read latency is 1 cycle: a request at edge N returns data valid after edge N+1, unless stall holds it.
- Write latency is 1 cycle: a read issued on the cycle after a write returns the written data. A read on the same cycle returns it through the bypass.
- The clear sequence takes exactly DEPTH_WORDS cycles after rst deasserts. busy falls on the edge after the last clear write, and the first request is accepted in the cycle where busy=0.
- conflict is registered and asserts the cycle after the colliding writes, for exactly 1 cycle per collision.
- stall affects only the read-data registers. It does not affect busy, the clear sequence, writes, conflict, or misalign_err.
- There is no backpressure: every request in READY is accepted in the cycle it is presented.

## Test plan
- Clear: CLEAR_ON_RST=1, DEPTH_WORDS=16; hold rst 2 cycles, then release. Required: busy=1 for exactly 16 cycles. A read of 0x3C issued once busy=0 returns 0. A write presented during busy is dropped, and a later read of that address returns 0.
- Basic store/load: write 0xDEADBEEF to 0x10 on lane 0, then read 0x10 on lane 1 the next cycle. Required: rd_data1=0xDEADBEEF one cycle after the read. Also read 0x50 with DEPTH_WORDS=16 and confirm it wraps to 0x10.
- Conflict and bypass: in one cycle, lane 0 writes 0x1111 to 0x20, lane 1 writes 0x2222 to 0x20, and lane 0 reads 0x20. Required: rd_data0=0x2222, conflict=1 for exactly one cycle, and a later read of 0x20 returns 0x2222.
- Stall hold: read 0x10, giving 0xDEADBEEF. Then assert stall for 3 cycles while reading 0x20 and writing 0x20. Required: rd_data0 stays 0xDEADBEEF throughout the stall, and the write to 0x20 is committed.
- Misalign: read 0x13 with rd_en0. Required: misalign_err=1 the next cycle, rd_data0 is the word at 0x10, and misalign_err stays high until rst.
- Reset mid-clear: assert rst when clr_idx=7. Required: busy lasts a fresh DEPTH_WORDS cycles from the release of rst, and all outputs return to their reset values.

Source files
------------

// File: rtl/lsu_dmem_responder.sv
// Dual-lane data-memory responder for the LSU: word-addressed RAM with
// registered load data, same-cycle store bypass, post-reset clear and error flags.
module lsu_dmem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] rd_addr0,
  input  logic [31:0] rd_addr1,
  input  logic        rd_en0,
  input  logic        rd_en1,
  output logic [31:0] rd_data0,
  output logic [31:0] rd_data1,
  input  logic [31:0] wr_addr0,
  input  logic [31:0] wr_addr1,
  input  logic [31:0] wr_data0,
  input  logic [31:0] wr_data1,
  input  logic        wr_en0,
  input  logic        wr_en1,
  output logic        busy,
  output logic        misalign_err,
  output logic        conflict
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_rd_data0;
  logic [31:0]   r_rd_data1;
  logic          r_misalign;
  logic          r_conflict;

  logic          w_ready;
  logic [AW-1:0] w_ri0;
  logic [AW-1:0] w_ri1;
  logic [AW-1:0] w_wi0;
  logic [AW-1:0] w_wi1;
  logic          w_same_wr;
  logic          w_mis_req;
  logic [31:0]   w_byp0;
  logic [31:0]   w_byp1;
  logic          w_unused_addr;

  assign w_ri0 = rd_addr0[AW+1:2];
  assign w_ri1 = rd_addr1[AW+1:2];
  assign w_wi0 = wr_addr0[AW+1:2];
  assign w_wi1 = wr_addr1[AW+1:2];
  assign w_unused_addr = ^{rd_addr0[31:AW+2], rd_addr1[31:AW+2],
                           wr_addr0[31:AW+2], wr_addr1[31:AW+2]};

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (r_clr_idx == LAST_IDX) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        w_ready = 1'b1;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + AW'(1);
    end
  end

  assign w_same_wr = wr_en0 && wr_en1 && (w_wi0 == w_wi1);
  assign w_mis_req = w_ready && ((rd_en0 && (rd_addr0[1:0] != 2'b00)) ||
                                 (rd_en1 && (rd_addr1[1:0] != 2'b00)) ||
                                 (wr_en0 && (wr_addr0[1:0] != 2'b00)) ||
                                 (wr_en1 && (wr_addr1[1:0] != 2'b00)));

  // Lane 1 store data takes precedence on the bypass, matching write priority.
  always_comb begin
    w_byp0 = r_mem[w_ri0];
    w_byp1 = r_mem[w_ri1];
    if (wr_en0 && (w_wi0 == w_ri0)) w_byp0 = wr_data0;
    if (wr_en1 && (w_wi1 == w_ri0)) w_byp0 = wr_data1;
    if (wr_en0 && (w_wi0 == w_ri1)) w_byp1 = wr_data0;
    if (wr_en1 && (w_wi1 == w_ri1)) w_byp1 = wr_data1;
  end

  // The later lane-1 assignment wins when both lanes hit the same word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else begin
        if (wr_en0) r_mem[w_wi0] <= wr_data0;
        if (wr_en1) r_mem[w_wi1] <= wr_data1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data0 <= '0;
      r_rd_data1 <= '0;
      r_misalign <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_ready && rd_en0 && !stall) r_rd_data0 <= w_byp0;
      if (w_ready && rd_en1 && !stall) r_rd_data1 <= w_byp1;
      if (w_mis_req) r_misalign <= 1'b1;
      r_conflict <= w_ready && w_same_wr;
    end
  end

  assign rd_data0     = r_rd_data0;
  assign rd_data1     = r_rd_data1;
  assign misalign_err = r_misalign;
  assign conflict     = r_conflict;

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// Bench for lsu_dmem_responder: directed vector table, reset/clear sequences,
// and randomized traffic against a rule-level memory model.
module tb_lsu_dmem_responder;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] rd_addr0, rd_addr1;
  logic        rd_en0, rd_en1;
  logic [31:0] rd_data0, rd_data1;
  logic [31:0] wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        wr_en0, wr_en1;
  logic        busy, misalign_err, conflict;

  int total = 0;
  int bad   = 0;

  lsu_dmem_responder #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_en0(rd_en0), .rd_en1(rd_en1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .busy(busy), .misalign_err(misalign_err), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: memory contents plus the number of clear cycles still owed.
  logic [31:0] m_mem [DEPTH];
  int          m_busy_left = 0;
  logic [31:0] m_rd0 = 0, m_rd1 = 0;
  logic        m_mis = 0, m_conf = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int r;
    r = widx(a);
    if (wr_en1 && widx(wr_addr1) == r) return wr_data1;
    if (wr_en0 && widx(wr_addr0) == r) return wr_data0;
    return m_mem[r];
  endfunction

  task automatic model_edge();
    logic [31:0] n0, n1;
    if (rst) begin
      m_busy_left = DEPTH;
      m_rd0 = 0; m_rd1 = 0; m_mis = 0; m_conf = 0;
    end else if (m_busy_left > 0) begin
      m_mem[DEPTH - m_busy_left] = 0;
      m_busy_left--;
      m_conf = 0;
    end else begin
      n0 = model_read(rd_addr0);
      n1 = model_read(rd_addr1);
      if (rd_en0 && !stall) m_rd0 = n0;
      if (rd_en1 && !stall) m_rd1 = n1;
      if (wr_en0) m_mem[widx(wr_addr0)] = wr_data0;
      if (wr_en1) m_mem[widx(wr_addr1)] = wr_data1;
      m_conf = wr_en0 && wr_en1 && (widx(wr_addr0) == widx(wr_addr1));
      if ((rd_en0 && rd_addr0[1:0] != 0) || (rd_en1 && rd_addr1[1:0] != 0) ||
          (wr_en0 && wr_addr0[1:0] != 0) || (wr_en1 && wr_addr1[1:0] != 0))
        m_mis = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en0 = 0; rd_en1 = 0; wr_en0 = 0; wr_en1 = 0; stall = 0;
    rd_addr0 = 0; rd_addr1 = 0; wr_addr0 = 0; wr_addr1 = 0;
    wr_data0 = 0; wr_data1 = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " rd_data0"}, rd_data0, m_rd0);
    chk({tag, " rd_data1"}, rd_data1, m_rd1);
    chk({tag, " conflict"}, {31'b0, conflict}, {31'b0, m_conf});
    chk({tag, " misalign"}, {31'b0, misalign_err}, {31'b0, m_mis});
    chk({tag, " busy"}, {31'b0, busy}, {31'b0, (m_busy_left > 0)});
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(tag, n, DEPTH);
  endtask

  typedef struct {
    logic        re0; logic [31:0] ra0;
    logic        re1; logic [31:0] ra1;
    logic        we0; logic [31:0] wa0; logic [31:0] wd0;
    logic        we1; logic [31:0] wa1; logic [31:0] wd1;
    logic        stl;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic        e_conf; logic e_mis;
  } vec_t;

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{0,32'h00,0,32'h00, 1,32'h10,32'hDEADBEEF, 0,32'h00,32'h0, 0, 32'h0,       32'h0,       0,0};
    vecs[1]  = '{0,32'h00,1,32'h10, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'h0,       32'hDEADBEEF,0,0};
    vecs[2]  = '{1,32'h50,0,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'hDEADBEEF,32'hDEADBEEF,0,0};
    vecs[3]  = '{1,32'h20,0,32'h00, 1,32'h20,32'h1111,     1,32'h20,32'h2222, 0, 32'h2222, 32'hDEADBEEF,1,0};
    vecs[4]  = '{0,32'h00,0,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'h2222,    32'hDEADBEEF,0,0};
    vecs[5]  = '{0,32'h00,1,32'h20, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'h2222,    32'h2222,    0,0};
    vecs[6]  = '{1,32'h10,0,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'hDEADBEEF,32'h2222,    0,0};
    vecs[7]  = '{1,32'h20,0,32'h00, 1,32'h20,32'h3333,     0,32'h00,32'h0, 1, 32'hDEADBEEF,32'h2222,    0,0};
    vecs[8]  = '{1,32'h20,0,32'h00, 1,32'h20,32'h3333,     0,32'h00,32'h0, 1, 32'hDEADBEEF,32'h2222,    0,0};
    vecs[9]  = '{1,32'h20,0,32'h00, 1,32'h20,32'h3333,     0,32'h00,32'h0, 1, 32'hDEADBEEF,32'h2222,    0,0};
    vecs[10] = '{1,32'h20,0,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'h3333,    32'h2222,    0,0};
    vecs[11] = '{1,32'h13,0,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'hDEADBEEF,32'h2222,    0,1};
    vecs[12] = '{0,32'h00,0,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'hDEADBEEF,32'h2222,    0,1};
    vecs[13] = '{1,32'h3C,0,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'h0,       32'h2222,    0,1};
    vecs[14] = '{0,32'h00,1,32'h00, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'h0,       32'h0,       0,1};
    vecs[15] = '{0,32'h00,0,32'h00, 1,32'h04,32'hAAAA,     1,32'h08,32'hBBBB, 0, 32'h0,    32'h0,       0,1};
    vecs[16] = '{1,32'h04,1,32'h08, 0,32'h00,32'h0,        0,32'h00,32'h0, 0, 32'hAAAA,    32'hBBBB,    0,1};
    vecs[17] = '{0,32'h00,1,32'h0C, 1,32'h0C,32'h5555,     0,32'h00,32'h0, 0, 32'hAAAA,    32'h5555,    0,1};

    idle_inputs();
    rst = 1;
    step();
    step();
    chk("reset rd_data0", rd_data0, 0);
    chk("reset rd_data1", rd_data1, 0);
    chk("reset misalign", {31'b0, misalign_err}, 0);
    chk("reset conflict", {31'b0, conflict}, 0);
    chk("reset busy", {31'b0, busy}, 1);

    // During the final clear cycle, present a store and a misaligned load; both must be dropped.
    rst = 0;
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        if (n == DEPTH - 1) begin
          wr_en0 = 1; wr_addr0 = 32'h00; wr_data0 = 32'hABCD;
          rd_en0 = 1; rd_addr0 = 32'h13;
        end
        step();
        idle_inputs();
        n++;
      end
      chk("clear busy cycles", n, DEPTH);
    end
    chk("clear rd_data0 held", rd_data0, 0);
    chk("clear misalign ignored", {31'b0, misalign_err}, 0);

    for (int i = 0; i < 18; i++) begin
      rd_en0 = vecs[i].re0; rd_addr0 = vecs[i].ra0;
      rd_en1 = vecs[i].re1; rd_addr1 = vecs[i].ra1;
      wr_en0 = vecs[i].we0; wr_addr0 = vecs[i].wa0; wr_data0 = vecs[i].wd0;
      wr_en1 = vecs[i].we1; wr_addr1 = vecs[i].wa1; wr_data1 = vecs[i].wd1;
      stall  = vecs[i].stl;
      step();
      chk($sformatf("vec%0d rd_data0", i), rd_data0, vecs[i].e_rd0);
      chk($sformatf("vec%0d rd_data1", i), rd_data1, vecs[i].e_rd1);
      chk($sformatf("vec%0d conflict", i), {31'b0, conflict}, {31'b0, vecs[i].e_conf});
      chk($sformatf("vec%0d misalign", i), {31'b0, misalign_err}, {31'b0, vecs[i].e_mis});
    end
    idle_inputs();

    // Random traffic: a narrow address range that wraps twice to provoke conflicts and bypasses.
    for (int i = 0; i < 400; i++) begin
      rd_en0 = 1'($urandom_range(0, 1));
      rd_en1 = 1'($urandom_range(0, 1));
      wr_en0 = 1'($urandom_range(0, 1));
      wr_en1 = 1'($urandom_range(0, 1));
      stall  = ($urandom_range(0, 3) == 0);
      rd_addr0 = {$urandom_range(0, 31), ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00};
      rd_addr1 = {$urandom_range(0, 31), 2'b00};
      wr_addr0 = {$urandom_range(0, 31), 2'b00};
      wr_addr1 = {$urandom_range(0, 31), 2'b00};
      wr_data0 = $urandom;
      wr_data1 = $urandom;
      step();
      chk_model($sformatf("rand%0d", i));
    end
    idle_inputs();

    // Reset from a dirty state, then interrupt the clear at clr_idx=7.
    rst = 1;
    step();
    chk_model("rst2");
    rst = 0;
    for (int i = 0; i < 7; i++) step();
    chk("midclear busy", {31'b0, busy}, 1);
    rst = 1;
    step();
    chk_model("rst3");
    rst = 0;
    count_busy("restart busy cycles");
    rd_en0 = 1; rd_addr0 = 32'h10;
    rd_en1 = 1; rd_addr1 = 32'h20;
    step();
    idle_inputs();
    chk("post-clear rd 0x10", rd_data0, 0);
    chk("post-clear rd 0x20", rd_data1, 0);
    chk_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
